// File: rtl/led_stream_if.sv
// Pin-side bundle of the LED stream decoder: raw serial input plus the decoded
// pixel/frame status it reports back.
interface led_stream_if;
    logic        din;
    logic [23:0] pixel;
    logic        pixel_valid;
    logic [9:0]  pixel_idx;
    logic        frame_done;
    logic [9:0]  frame_len;
    logic        bit_err;
    logic        overflow;

    modport master (
        output din,
        input  pixel, pixel_valid, pixel_idx, frame_done, frame_len, bit_err, overflow
    );

    modport slave (
        input  din,
        output pixel, pixel_valid, pixel_idx, frame_done, frame_len, bit_err, overflow
    );
endinterface

// File: rtl/led_stream_decoder.sv
// Single-wire addressable-LED receiver: measures high pulses into bits, packs 24-bit
// pixels MSB-first and reports frames delimited by the long-low latch gap.
module led_stream_decoder #(
    parameter int T_THRESH   = 29,
    parameter int T_MIN_HIGH = 5,
    parameter int T_MAX_HIGH = 96,
    parameter int T_RESET    = 2400,
    parameter int NUM_LEDS   = 144
) (
    input logic        clk,
    input logic        rst,
    led_stream_if.slave bus
);
    localparam int HW = $clog2(T_MAX_HIGH + 1);
    localparam int LW = $clog2(T_RESET + 1);
    localparam logic [HW-1:0] HMAX  = HW'(T_MAX_HIGH);
    localparam logic [HW-1:0] HMIN  = HW'(T_MIN_HIGH);
    localparam logic [HW-1:0] HTHR  = HW'(T_THRESH);
    localparam logic [LW-1:0] LMAX  = LW'(T_RESET);
    localparam logic [9:0]    NLEDS = 10'(NUM_LEDS);

    typedef enum logic [1:0] {SYNC, IDLE, HIGH, LOW} state_t;

    state_t          state, state_nxt;
    logic [1:0]      sync_ff;
    logic            din_s;
    logic [HW-1:0]   high_cnt, high_nxt, high_inc;
    logic [LW-1:0]   low_cnt, low_nxt, low_inc;
    logic            shift_en, shift_bit, err_ev, fend_ev;

    logic [23:0]     shreg;
    logic [4:0]      bit_cnt;
    logic [9:0]      pix_cnt;
    logic [23:0]     pixel_q;
    logic            pixel_valid_q;
    logic [9:0]      pixel_idx_q;
    logic            frame_done_q;
    logic [9:0]      frame_len_q;
    logic            bit_err_q;
    logic            overflow_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) sync_ff <= 2'b00;
        else     sync_ff <= {sync_ff[0], bus.din};
    end
    assign din_s = sync_ff[1];

    assign high_inc = (high_cnt == HMAX) ? high_cnt : high_cnt + 1'b1;
    assign low_inc  = (low_cnt  == LMAX) ? low_cnt  : low_cnt  + 1'b1;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= SYNC;
            high_cnt <= '0;
            low_cnt  <= '0;
        end else begin
            state    <= state_nxt;
            high_cnt <= high_nxt;
            low_cnt  <= low_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        high_nxt  = high_cnt;
        low_nxt   = low_cnt;
        shift_en  = 1'b0;
        shift_bit = 1'b0;
        err_ev    = 1'b0;
        fend_ev   = 1'b0;
        case (state)
            SYNC: begin
                if (din_s) begin
                    low_nxt = '0;
                end else begin
                    low_nxt = low_inc;
                    if (low_inc == LMAX) state_nxt = IDLE;
                end
            end
            IDLE: begin
                if (din_s) begin
                    state_nxt = HIGH;
                    high_nxt  = HW'(1);
                    low_nxt   = '0;
                end else begin
                    low_nxt = low_inc;
                    // Only a gap that actually ends a non-empty frame reports frame end
                    if (low_inc == LMAX && low_cnt != LMAX && (pix_cnt != '0 || bit_cnt != '0))
                        fend_ev = 1'b1;
                end
            end
            HIGH: begin
                if (din_s) begin
                    high_nxt = high_inc;
                    if (high_inc == HMAX) begin
                        err_ev    = 1'b1;
                        state_nxt = SYNC;
                        low_nxt   = '0;
                    end
                end else if (high_cnt < HMIN) begin
                    err_ev    = 1'b1;
                    state_nxt = SYNC;
                    low_nxt   = '0;
                end else begin
                    shift_en  = 1'b1;
                    shift_bit = (high_cnt >= HTHR);
                    state_nxt = LOW;
                    low_nxt   = LW'(1);
                end
            end
            LOW: begin
                if (din_s) begin
                    state_nxt = HIGH;
                    high_nxt  = HW'(1);
                    low_nxt   = '0;
                end else begin
                    low_nxt = low_inc;
                    if (low_inc == LMAX) begin
                        fend_ev   = 1'b1;
                        state_nxt = IDLE;
                    end
                end
            end
            default: state_nxt = SYNC;
        endcase
    end

    // The 24th bit is published on the same edge it is shifted in.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            shreg         <= '0;
            bit_cnt       <= '0;
            pix_cnt       <= '0;
            pixel_q       <= '0;
            pixel_valid_q <= 1'b0;
            pixel_idx_q   <= '0;
            frame_done_q  <= 1'b0;
            frame_len_q   <= '0;
            bit_err_q     <= 1'b0;
            overflow_q    <= 1'b0;
        end else begin
            pixel_valid_q <= 1'b0;
            frame_done_q  <= 1'b0;
            bit_err_q     <= 1'b0;
            if (shift_en) begin
                shreg <= {shreg[22:0], shift_bit};
                if (bit_cnt == 5'd23) begin
                    bit_cnt <= '0;
                    if (pix_cnt >= NLEDS) begin
                        overflow_q <= 1'b1;
                    end else begin
                        pixel_q       <= {shreg[22:0], shift_bit};
                        pixel_valid_q <= 1'b1;
                        pixel_idx_q   <= pix_cnt;
                        pix_cnt       <= pix_cnt + 1'b1;
                    end
                end else begin
                    bit_cnt <= bit_cnt + 1'b1;
                end
            end
            if (err_ev) begin
                bit_err_q <= 1'b1;
                bit_cnt   <= '0;
            end
            if (fend_ev) begin
                frame_done_q <= 1'b1;
                frame_len_q  <= pix_cnt;
                bit_err_q    <= (bit_cnt != '0);
                pix_cnt      <= '0;
                bit_cnt      <= '0;
                overflow_q   <= 1'b0;
            end
        end
    end

    assign bus.pixel       = pixel_q;
    assign bus.pixel_valid = pixel_valid_q;
    assign bus.pixel_idx   = pixel_idx_q;
    assign bus.frame_done  = frame_done_q;
    assign bus.frame_len   = frame_len_q;
    assign bus.bit_err     = bit_err_q;
    assign bus.overflow    = overflow_q;
endmodule

// File: tb/tb_led_stream_decoder.sv
// Bench for led_stream_decoder: drives pulse-width-coded frames, scoreboards pixels
// and frame-end reports, and walks the pulse-length and reset corner cases.
module tb_led_stream_decoder;
    localparam int TR = 300;
    localparam int NL = 6;

    typedef struct { logic [23:0] data; logic [9:0] idx; } px_t;
    typedef struct { logic [9:0] len; logic err; } fr_t;
    typedef struct { int npix; logic [23:0] base; logic [23:0] step; int extra; logic ovf; } frame_vec_t;
    typedef struct { int hlen; int exp_err; } pulse_vec_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    led_stream_if bus();
    led_stream_decoder #(.T_RESET(TR), .NUM_LEDS(NL)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int total = 0, bad = 0, err_strobes = 0;
    int cyc = 0, last_fall = 0, pv_cyc = 0;
    px_t px_q[$];
    fr_t fr_q[$];
    logic [23:0] last_data = '0;
    px_t mon_px;
    fr_t mon_fr;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (!rst) begin
            if (bus.pixel_valid) begin
                pv_cyc = cyc;
                if (px_q.size() == 0) begin
                    chk("pixel_unexpected", {8'h0, bus.pixel}, 32'hFFFF_FFFF);
                end else begin
                    mon_px = px_q.pop_front();
                    chk("pixel_data", {8'h0, bus.pixel}, {8'h0, mon_px.data});
                    chk("pixel_idx", {22'h0, bus.pixel_idx}, {22'h0, mon_px.idx});
                end
            end
            if (bus.frame_done) begin
                if (fr_q.size() == 0) begin
                    chk("frame_unexpected", {22'h0, bus.frame_len}, 32'hFFFF_FFFF);
                end else begin
                    mon_fr = fr_q.pop_front();
                    chk("frame_len", {22'h0, bus.frame_len}, {22'h0, mon_fr.len});
                    chk("frame_bit_err", {31'h0, bus.bit_err}, {31'h0, mon_fr.err});
                end
            end else if (bus.bit_err) begin
                err_strobes++;
            end
        end
    end

    task automatic send_bit(int h, int lo);
        bus.din = 1'b1;
        repeat (h) @(posedge clk);
        #1 bus.din = 1'b0;
        last_fall = cyc;
        repeat (lo) @(posedge clk);
        #1;
    endtask

    task automatic send_low(int n);
        bus.din = 1'b0;
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic send_pixel(logic [23:0] d);
        for (int b = 23; b >= 0; b--) begin
            if (d[b]) send_bit(38, 22);
            else      send_bit(19, 41);
        end
    endtask

    task automatic run_frame(frame_vec_t v, int start);
        int e0, idx, exp_len;
        logic [23:0] d;
        e0 = err_strobes;
        for (int i = 0; i < v.npix; i++) begin
            d   = v.base + v.step * 24'(i);
            idx = start + i;
            if (idx < NL) begin
                px_q.push_back('{data: d, idx: 10'(idx)});
                last_data = d;
            end
            send_pixel(d);
        end
        if (v.extra == 0 && start + v.npix <= NL)
            chk("pixel_latency", pv_cyc - last_fall, 3);
        for (int i = 0; i < v.extra; i++) send_bit(38, 22);
        @(negedge clk);
        chk("overflow_in_frame", {31'h0, bus.overflow}, {31'h0, v.ovf});
        exp_len = (start + v.npix > NL) ? NL : start + v.npix;
        fr_q.push_back('{len: 10'(exp_len), err: (v.extra != 0)});
        send_low(TR + 10);
        chk("pixels_drained", px_q.size(), 0);
        chk("frames_drained", fr_q.size(), 0);
        chk("overflow_cleared", {31'h0, bus.overflow}, 0);
        chk("frame_len_held", {22'h0, bus.frame_len}, exp_len);
        chk("pixel_held", {8'h0, bus.pixel}, {8'h0, last_data});
        chk("no_stray_bit_err", err_strobes - e0, 0);
    endtask

    frame_vec_t fv[5];
    pulse_vec_t pv[5];
    frame_vec_t fv_resume, fv_rst;
    int e0;

    initial begin
        fv[0] = '{npix: 1,      base: 24'hFF0000, step: 24'h000000, extra: 0, ovf: 1'b0};
        fv[1] = '{npix: NL,     base: 24'h000000, step: 24'h010203, extra: 0, ovf: 1'b0};
        fv[2] = '{npix: NL + 2, base: 24'h123456, step: 24'h0F0F0F, extra: 0, ovf: 1'b1};
        fv[3] = '{npix: 1,      base: 24'hA5A5A5, step: 24'h000000, extra: 6, ovf: 1'b0};
        fv[4] = '{npix: 2,      base: 24'hFFFFFF, step: 24'hFFFFFF, extra: 0, ovf: 1'b0};
        pv[0] = '{hlen: 4,  exp_err: 1};
        pv[1] = '{hlen: 5,  exp_err: 0};
        pv[2] = '{hlen: 95, exp_err: 0};
        pv[3] = '{hlen: 96, exp_err: 1};
        pv[4] = '{hlen: 2,  exp_err: 1};
        fv_resume = '{npix: 2, base: 24'h0C0FFE, step: 24'h111111, extra: 0, ovf: 1'b0};
        fv_rst    = '{npix: 2, base: 24'h00FF00, step: 24'h010101, extra: 0, ovf: 1'b0};

        bus.din = 1'b0;
        rst = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_pixel", {8'h0, bus.pixel}, 0);
        chk("rst_pixel_valid", {31'h0, bus.pixel_valid}, 0);
        chk("rst_frame_len", {22'h0, bus.frame_len}, 0);
        chk("rst_strobes", {29'h0, bus.frame_done, bus.bit_err, bus.overflow}, 0);
        @(posedge clk);
        #1 rst = 1'b0;
        send_low(TR + 10);

        for (int i = 0; i < 5; i++) run_frame(fv[i], 0);

        // Threshold edges: 29 -> 1, 28 -> 0, 5 -> 0, 95 -> 1
        px_q.push_back('{data: 24'h999999, idx: 10'd0});
        last_data = 24'h999999;
        for (int n = 0; n < 6; n++) begin
            send_bit(29, 20); send_bit(28, 20); send_bit(5, 20); send_bit(95, 20);
        end
        fr_q.push_back('{len: 10'd1, err: 1'b0});
        send_low(TR + 10);
        chk("thresh_px_drained", px_q.size(), 0);
        chk("thresh_fr_drained", fr_q.size(), 0);

        // Lone pulses: errors go to resync silently, valid bits end as a partial frame
        for (int p = 0; p < 5; p++) begin
            e0 = err_strobes;
            if (pv[p].exp_err == 0) fr_q.push_back('{len: 10'd0, err: 1'b1});
            send_bit(pv[p].hlen, 10);
            send_low(TR + 10);
            chk("pulse_bit_err", err_strobes - e0, pv[p].exp_err);
            chk("pulse_frames", fr_q.size(), 0);
        end

        // Glitch inside pixel 3: pixel dropped, count kept across the resync
        e0 = err_strobes;
        for (int i = 0; i < 3; i++) begin
            px_q.push_back('{data: 24'h300000 + 24'(i), idx: 10'(i)});
            last_data = 24'h300000 + 24'(i);
            send_pixel(24'h300000 + 24'(i));
        end
        for (int b = 0; b < 5; b++) send_bit(38, 22);
        send_bit(2, 20);
        for (int b = 0; b < 18; b++) send_bit(19, 41);
        send_low(TR + 10);
        chk("glitch_bit_err", err_strobes - e0, 1);
        chk("glitch_px_drained", px_q.size(), 0);
        chk("glitch_no_frame", fr_q.size(), 0);
        run_frame(fv_resume, 3);

        // Reset during bit 12 of the second pixel
        px_q.push_back('{data: 24'hAAAAAA, idx: 10'd0});
        last_data = 24'hAAAAAA;
        send_pixel(24'hAAAAAA);
        for (int b = 0; b < 11; b++) send_bit(38, 22);
        bus.din = 1'b1;
        repeat (10) @(posedge clk);
        #1 rst = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("midrst_pixel", {8'h0, bus.pixel}, 0);
        chk("midrst_idx", {22'h0, bus.pixel_idx}, 0);
        chk("midrst_frame_len", {22'h0, bus.frame_len}, 0);
        chk("midrst_strobes", {28'h0, bus.pixel_valid, bus.frame_done, bus.bit_err, bus.overflow}, 0);
        chk("midrst_px_drained", px_q.size(), 0);
        bus.din = 1'b0;
        @(posedge clk);
        #1 rst = 1'b0;
        send_pixel(24'h111111);
        send_low(TR + 10);
        chk("post_rst_ignored", px_q.size(), 0);
        run_frame(fv_rst, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
